// File: rtl/dcache_dram_manager.sv
// dcache_dram_manager
//   Responder side of the LSU <-> DRAM-manager link for the data cache.
//   Owns the direct-mapped tag RAM (2**IDX_W sets) and data RAM
//   (LINE_WORDS words per set), answers EX-stage lookups one cycle later,
//   absorbs writes into a one-entry write-through buffer, and runs refill,
//   uncached-read and invalidate operations over a single-master bus.
//   Every RAM write is mirrored on the snp_* ports.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   rd_*                : lookup request / registered result
//   wr_*, pending_write : write request, accept, buffer occupancy
//   op_*, uncached_rdata: operation request, completion pulse, uncached data
//   snp_*               : tag/data RAM write broadcast
//   bus_*               : single-master bus (request/grant, read beats, write response)
module dcache_dram_manager #(
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rd_valid_i,
  input  logic [31:0]                          rd_vaddr_i,
  output logic                                 rd_valid_d1_o,
  output logic [31:0]                          rd_data_d1_o,
  output logic [20:0]                          rd_tag_d1_o,
  input  logic                                 wr_valid_i,
  input  logic [31:0]                          wr_addr_i,
  input  logic [31:0]                          wr_data_i,
  input  logic [3:0]                           wr_strobe_i,
  input  logic                                 wr_uncached_i,
  output logic                                 wr_ready_o,
  output logic                                 pending_write_o,
  input  logic                                 op_valid_i,
  input  logic [2:0]                           op_type_i,
  input  logic [31:0]                          op_addr_i,
  input  logic                                 op_uncached_i,
  input  logic [1:0]                           op_size_i,
  output logic                                 op_ready_o,
  output logic [31:0]                          uncached_rdata_o,
  output logic                                 snp_tag_we_o,
  output logic [IDX_W-1:0]                     snp_tag_waddr_o,
  output logic [20:0]                          snp_tag_wdata_o,
  output logic                                 snp_data_we_o,
  output logic [IDX_W+$clog2(LINE_WORDS)-1:0]  snp_data_waddr_o,
  output logic [31:0]                          snp_data_wdata_o,
  output logic                                 bus_req_o,
  output logic                                 bus_we_o,
  output logic [31:0]                          bus_addr_o,
  output logic [1:0]                           bus_len_o,
  output logic [1:0]                           bus_size_o,
  output logic [3:0]                           bus_strobe_o,
  output logic [31:0]                          bus_wdata_o,
  input  logic                                 bus_gnt_i,
  input  logic                                 bus_rvalid_i,
  input  logic [31:0]                          bus_rdata_i,
  input  logic                                 bus_rlast_i,
  input  logic                                 bus_bvalid_i
);

  localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
  localparam int unsigned DADDR_W = IDX_W + WORD_W;
  localparam int unsigned OFF_W   = WORD_W + 2;
  localparam logic [2:0]  OPT_READ = 3'd1;
  localparam logic [2:0]  OPT_INV  = 3'd3;

  typedef enum logic [1:0] {WB_EMPTY, WB_REQ, WB_WAIT_B} wb_state_e;
  typedef enum logic [2:0] {
    OP_IDLE, OP_DRAIN, OP_REFILL_REQ, OP_REFILL_DATA,
    OP_UREAD_REQ, OP_UREAD_DATA, OP_INV, OP_DONE
  } op_state_e;

  logic [31:0] data_ram [2**DADDR_W];
  logic [20:0] tag_ram  [2**IDX_W];

  logic               init_q, init_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
  wb_state_e          wb_state_q, wb_state_d;
  logic [31:0]        wb_addr_q, wb_addr_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [3:0]         wb_strobe_q, wb_strobe_d;
  logic [1:0]         wb_size_q, wb_size_d;
  op_state_e          op_state_q, op_state_d, dispatch_state;
  logic [WORD_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic               tag_pend_q, tag_pend_d;
  logic [31:0]        ur_data_q, ur_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [20:0]        rd_tag_q, rd_tag_d;

  logic               wr_accept;
  logic [IDX_W-1:0]   op_idx;

  assign op_idx    = op_addr_i[OFF_W +: IDX_W];
  assign wr_accept = wr_valid_i & wr_ready_o;

  assign wr_ready_o       = (wb_state_q == WB_EMPTY) && !init_q &&
                            ((op_state_q == OP_IDLE) || (op_state_q == OP_DONE));
  assign pending_write_o  = (wb_state_q != WB_EMPTY);
  assign op_ready_o       = (op_state_q == OP_DONE);
  assign uncached_rdata_o = ur_data_q;
  assign rd_valid_d1_o    = rd_valid_q;
  assign rd_data_d1_o     = rd_data_q;
  assign rd_tag_d1_o      = rd_tag_q;

  // Lookup: registered read of both RAMs; a same-cycle write returns old data.
  always_comb begin
    rd_valid_d = rd_valid_i && !init_q;
    rd_data_d  = data_ram[rd_vaddr_i[2 +: DADDR_W]];
    rd_tag_d   = tag_ram[rd_vaddr_i[OFF_W +: IDX_W]];
  end

  // Write buffer
  always_comb begin
    wb_state_d  = wb_state_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_strobe_d = wb_strobe_q;
    wb_size_d   = wb_size_q;
    case (wb_state_q)
      WB_EMPTY: begin
        if (wr_accept) begin
          wb_state_d  = WB_REQ;
          wb_addr_d   = wr_addr_i;
          wb_data_d   = wr_data_i;
          wb_strobe_d = wr_strobe_i;
          case (wr_strobe_i)
            4'hF:       wb_size_d = 2'd2;
            4'h3, 4'hC: wb_size_d = 2'd1;
            default:    wb_size_d = 2'd0;
          endcase
        end
      end
      WB_REQ:    if (bus_gnt_i)    wb_state_d = WB_WAIT_B;
      WB_WAIT_B: if (bus_bvalid_i) wb_state_d = WB_EMPTY;
      default:   wb_state_d = WB_EMPTY;
    endcase
  end

  always_comb begin
    if (op_type_i == OPT_READ) begin
      dispatch_state = op_uncached_i ? OP_UREAD_REQ : OP_REFILL_REQ;
    end else if (op_type_i == OPT_INV) begin
      dispatch_state = OP_INV;
    end else begin
      dispatch_state = OP_DONE;
    end
  end

  // INIT sweep, operation FSM and the shared RAM write ports.
  always_comb begin
    init_d           = init_q;
    init_cnt_d       = init_cnt_q;
    op_state_d       = op_state_q;
    beat_cnt_d       = beat_cnt_q;
    tag_pend_d       = tag_pend_q;
    ur_data_d        = ur_data_q;
    snp_tag_we_o     = 1'b0;
    snp_tag_waddr_o  = '0;
    snp_tag_wdata_o  = '0;
    snp_data_we_o    = 1'b0;
    snp_data_waddr_o = '0;
    snp_data_wdata_o = '0;

    if (init_q) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) init_d = 1'b0;
      // Gated by rst so the sweep strobe stays low while reset is held.
      snp_tag_we_o    = !rst;
      snp_tag_waddr_o = init_cnt_q;
    end

    if (wr_accept && !wr_uncached_i) begin
      snp_data_we_o    = 1'b1;
      snp_data_waddr_o = wr_addr_i[2 +: DADDR_W];
      snp_data_wdata_o = wr_data_i;
    end

    case (op_state_q)
      OP_IDLE: begin
        if (op_valid_i && !init_q) begin
          // A write accepted in this same cycle must drain first too.
          if ((wb_state_q != WB_EMPTY) || wr_accept) op_state_d = OP_DRAIN;
          else                                       op_state_d = dispatch_state;
        end
      end
      OP_DRAIN: if (wb_state_q == WB_EMPTY) op_state_d = dispatch_state;
      OP_REFILL_REQ: begin
        if (bus_gnt_i) begin
          op_state_d = OP_REFILL_DATA;
          beat_cnt_d = '0;
          tag_pend_d = 1'b0;
        end
      end
      OP_REFILL_DATA: begin
        if (tag_pend_q) begin
          // Tag goes in the cycle after the last beat so a valid tag
          // never precedes its line data.
          snp_tag_we_o    = 1'b1;
          snp_tag_waddr_o = op_idx;
          snp_tag_wdata_o = {1'b1, op_addr_i[31:12]};
          tag_pend_d      = 1'b0;
          op_state_d      = OP_DONE;
        end else if (bus_rvalid_i) begin
          snp_data_we_o    = 1'b1;
          snp_data_waddr_o = {op_idx, beat_cnt_q};
          snp_data_wdata_o = bus_rdata_i;
          beat_cnt_d       = beat_cnt_q + 1'b1;
          if (bus_rlast_i) tag_pend_d = 1'b1;
        end
      end
      OP_UREAD_REQ: if (bus_gnt_i) op_state_d = OP_UREAD_DATA;
      OP_UREAD_DATA: begin
        if (bus_rvalid_i) begin
          ur_data_d  = bus_rdata_i;
          op_state_d = OP_DONE;
        end
      end
      OP_INV: begin
        snp_tag_we_o    = 1'b1;
        snp_tag_waddr_o = op_idx;
        op_state_d      = OP_DONE;
      end
      OP_DONE: op_state_d = OP_IDLE;
      default: op_state_d = OP_IDLE;
    endcase
  end

  // Bus mux: the write buffer wins; the op FSM only requests when it is empty.
  always_comb begin
    bus_req_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_len_o    = '0;
    bus_size_o   = '0;
    bus_strobe_o = '0;
    bus_wdata_o  = '0;
    if (wb_state_q == WB_REQ) begin
      bus_req_o    = 1'b1;
      bus_we_o     = 1'b1;
      bus_addr_o   = wb_addr_q;
      bus_size_o   = wb_size_q;
      bus_strobe_o = wb_strobe_q;
      bus_wdata_o  = wb_data_q;
    end else if (op_state_q == OP_REFILL_REQ) begin
      bus_req_o  = 1'b1;
      bus_addr_o = {op_addr_i[31:OFF_W], {OFF_W{1'b0}}};
      bus_len_o  = 2'(LINE_WORDS - 1);
      bus_size_o = 2'd2;
    end else if (op_state_q == OP_UREAD_REQ) begin
      bus_req_o  = 1'b1;
      bus_addr_o = op_addr_i;
      bus_size_o = op_size_i;
    end
  end

  always_ff @(posedge clk) begin
    if (snp_tag_we_o)  tag_ram[snp_tag_waddr_o]   <= snp_tag_wdata_o;
    if (snp_data_we_o) data_ram[snp_data_waddr_o] <= snp_data_wdata_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q      <= 1'b1;
      init_cnt_q  <= '0;
      wb_state_q  <= WB_EMPTY;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_strobe_q <= '0;
      wb_size_q   <= '0;
      op_state_q  <= OP_IDLE;
      beat_cnt_q  <= '0;
      tag_pend_q  <= 1'b0;
      ur_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_tag_q    <= '0;
    end else begin
      init_q      <= init_d;
      init_cnt_q  <= init_cnt_d;
      wb_state_q  <= wb_state_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_strobe_q <= wb_strobe_d;
      wb_size_q   <= wb_size_d;
      op_state_q  <= op_state_d;
      beat_cnt_q  <= beat_cnt_d;
      tag_pend_q  <= tag_pend_d;
      ur_data_q   <= ur_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

endmodule

// File: tb/tb_dcache_dram_manager.sv
// Directed testbench for dcache_dram_manager. Inputs change on the falling
// edge; outputs are sampled 1 time unit later.
module tb_dcache_dram_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid_i;
  logic [31:0] rd_vaddr_i;
  logic        rd_valid_d1_o;
  logic [31:0] rd_data_d1_o;
  logic [20:0] rd_tag_d1_o;
  logic        wr_valid_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_strobe_i;
  logic        wr_uncached_i;
  logic        wr_ready_o;
  logic        pending_write_o;
  logic        op_valid_i;
  logic [2:0]  op_type_i;
  logic [31:0] op_addr_i;
  logic        op_uncached_i;
  logic [1:0]  op_size_i;
  logic        op_ready_o;
  logic [31:0] uncached_rdata_o;
  logic        snp_tag_we_o;
  logic [7:0]  snp_tag_waddr_o;
  logic [20:0] snp_tag_wdata_o;
  logic        snp_data_we_o;
  logic [9:0]  snp_data_waddr_o;
  logic [31:0] snp_data_wdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [1:0]  bus_len_o;
  logic [1:0]  bus_size_o;
  logic [3:0]  bus_strobe_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_rlast_i;
  logic        bus_bvalid_i;

  int errors;
  int checks;

  always #5 clk = ~clk;

  dcache_dram_manager #(.IDX_W(8), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .rd_valid_i(rd_valid_i), .rd_vaddr_i(rd_vaddr_i),
    .rd_valid_d1_o(rd_valid_d1_o), .rd_data_d1_o(rd_data_d1_o), .rd_tag_d1_o(rd_tag_d1_o),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_strobe_i(wr_strobe_i), .wr_uncached_i(wr_uncached_i),
    .wr_ready_o(wr_ready_o), .pending_write_o(pending_write_o),
    .op_valid_i(op_valid_i), .op_type_i(op_type_i), .op_addr_i(op_addr_i),
    .op_uncached_i(op_uncached_i), .op_size_i(op_size_i),
    .op_ready_o(op_ready_o), .uncached_rdata_o(uncached_rdata_o),
    .snp_tag_we_o(snp_tag_we_o), .snp_tag_waddr_o(snp_tag_waddr_o), .snp_tag_wdata_o(snp_tag_wdata_o),
    .snp_data_we_o(snp_data_we_o), .snp_data_waddr_o(snp_data_waddr_o), .snp_data_wdata_o(snp_data_wdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_len_o(bus_len_o), .bus_size_o(bus_size_o), .bus_strobe_o(bus_strobe_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_rlast_i(bus_rlast_i), .bus_bvalid_i(bus_bvalid_i)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({wr_ready_o, pending_write_o, op_ready_o, rd_valid_d1_o, snp_tag_we_o, snp_data_we_o, bus_req_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000", {wr_ready_o, pending_write_o, op_ready_o, rd_valid_d1_o, snp_tag_we_o, snp_data_we_o, bus_req_o});
    end
    checks++;
    if ({rd_data_d1_o, rd_tag_d1_o, uncached_rdata_o, bus_addr_o} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {rd_data_d1_o, rd_tag_d1_o, uncached_rdata_o, bus_addr_o});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      checks++;
      if ({snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, wr_ready_o} !== {1'b1, 8'(i), 21'h0, 1'b0}) begin
        errors++; $display("FAIL init_sweep[%0d]: got we=%b idx=%h data=%h rdy=%b want we=1 idx=%h data=0 rdy=0",
                           i, snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, wr_ready_o, 8'(i));
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({wr_ready_o, snp_tag_we_o} !== 2'b10) begin
      errors++; $display("FAIL init_done: got rdy=%b tag_we=%b want rdy=1 tag_we=0", wr_ready_o, snp_tag_we_o);
    end
  endtask

  task automatic test_cached_write();
    @(negedge clk);
    wr_valid_i = 1'b1; wr_addr_i = 32'h1000_0040; wr_data_i = 32'hDEAD_BEEF;
    wr_strobe_i = 4'hF; wr_uncached_i = 1'b0;
    #1;
    checks++;
    if ({wr_ready_o, snp_data_we_o, snp_data_waddr_o, snp_data_wdata_o} !== {1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL cw_accept: got rdy=%b we=%b addr=%h data=%h want 1 1 010 deadbeef",
                         wr_ready_o, snp_data_we_o, snp_data_waddr_o, snp_data_wdata_o);
    end
    @(negedge clk);
    wr_valid_i = 1'b0; rd_valid_i = 1'b1; rd_vaddr_i = 32'h0000_0040; bus_gnt_i = 1'b1;
    #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_len_o, bus_size_o, bus_strobe_o, bus_wdata_o} !==
        {1'b1, 1'b1, 32'h1000_0040, 2'd0, 2'd2, 4'hF, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL cw_bus: got req=%b we=%b addr=%h len=%0d size=%0d strb=%h data=%h want 1 1 10000040 0 2 f deadbeef",
                         bus_req_o, bus_we_o, bus_addr_o, bus_len_o, bus_size_o, bus_strobe_o, bus_wdata_o);
    end
    checks++;
    if ({pending_write_o, wr_ready_o} !== 2'b10) begin
      errors++; $display("FAIL cw_pending: got pend=%b rdy=%b want pend=1 rdy=0", pending_write_o, wr_ready_o);
    end
    @(negedge clk);
    rd_valid_i = 1'b0; bus_gnt_i = 1'b0;
    #1;
    checks++;
    if ({rd_valid_d1_o, rd_data_d1_o, rd_tag_d1_o} !== {1'b1, 32'hDEAD_BEEF, 21'h0}) begin
      errors++; $display("FAIL cw_lookup: got v=%b data=%h tag=%h want 1 deadbeef 000000", rd_valid_d1_o, rd_data_d1_o, rd_tag_d1_o);
    end
    checks++;
    if ({bus_req_o, pending_write_o} !== 2'b01) begin
      errors++; $display("FAIL cw_wait_b: got req=%b pend=%b want req=0 pend=1", bus_req_o, pending_write_o);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (pending_write_o !== 1'b1) begin
      errors++; $display("FAIL cw_hold: got pend=%b want 1", pending_write_o);
    end
    @(negedge clk); bus_bvalid_i = 1'b1;
    @(negedge clk); bus_bvalid_i = 1'b0;
    #1;
    checks++;
    if ({pending_write_o, wr_ready_o} !== 2'b01) begin
      errors++; $display("FAIL cw_bvalid: got pend=%b rdy=%b want pend=0 rdy=1", pending_write_o, wr_ready_o);
    end
  endtask

  task automatic test_refill();
    logic [31:0] beats [4];
    beats[0] = 32'hAAAA_0000; beats[1] = 32'hBBBB_1111;
    beats[2] = 32'hCCCC_2222; beats[3] = 32'hDDDD_3333;
    @(negedge clk);
    op_valid_i = 1'b1; op_type_i = 3'd1; op_addr_i = 32'h8000_1230; op_uncached_i = 1'b0; op_size_i = 2'd0;
    #1;
    checks++;
    if ({bus_req_o, op_ready_o} !== 2'b00) begin
      errors++; $display("FAIL rf_idle: got req=%b rdy=%b want 0 0", bus_req_o, op_ready_o);
    end
    @(negedge clk); bus_gnt_i = 1'b1; #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_len_o, bus_size_o, wr_ready_o} !== {1'b1, 1'b0, 32'h8000_1230, 2'd3, 2'd2, 1'b0}) begin
      errors++; $display("FAIL rf_req: got req=%b we=%b addr=%h len=%0d size=%0d wrdy=%b want 1 0 80001230 3 2 0",
                         bus_req_o, bus_we_o, bus_addr_o, bus_len_o, bus_size_o, wr_ready_o);
    end
    @(negedge clk); bus_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_rvalid_i = 1'b1; bus_rdata_i = beats[k]; bus_rlast_i = (k == 3);
      #1;
      checks++;
      if ({snp_tag_we_o, snp_data_we_o, snp_data_waddr_o, snp_data_wdata_o} !== {1'b0, 1'b1, 10'(140 + k), beats[k]}) begin
        errors++; $display("FAIL rf_beat[%0d]: got tag_we=%b we=%b addr=%h data=%h want 0 1 %h %h",
                           k, snp_tag_we_o, snp_data_we_o, snp_data_waddr_o, snp_data_wdata_o, 10'(140 + k), beats[k]);
      end
    end
    @(negedge clk); bus_rvalid_i = 1'b0; bus_rlast_i = 1'b0; #1;
    checks++;
    if ({snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, snp_data_we_o, op_ready_o} !== {1'b1, 8'h23, 21'h18_0001, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rf_tag: got we=%b idx=%h tag=%h dwe=%b rdy=%b want 1 23 180001 0 0",
                         snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, snp_data_we_o, op_ready_o);
    end
    @(negedge clk); op_valid_i = 1'b0; rd_valid_i = 1'b1; rd_vaddr_i = 32'h0000_0234; #1;
    checks++;
    if ({op_ready_o, snp_tag_we_o} !== 2'b10) begin
      errors++; $display("FAIL rf_ready: got rdy=%b tag_we=%b want 1 0", op_ready_o, snp_tag_we_o);
    end
    @(negedge clk); rd_valid_i = 1'b0; #1;
    checks++;
    if ({op_ready_o, rd_data_d1_o, rd_tag_d1_o} !== {1'b0, 32'hBBBB_1111, 21'h18_0001}) begin
      errors++; $display("FAIL rf_hit: got rdy=%b data=%h tag=%h want 0 bbbb1111 180001", op_ready_o, rd_data_d1_o, rd_tag_d1_o);
    end
  endtask

  task automatic test_drain();
    @(negedge clk);
    wr_valid_i = 1'b1; wr_uncached_i = 1'b1; wr_addr_i = 32'hBFD0_0010; wr_data_i = 32'h0000_0055; wr_strobe_i = 4'h1;
    #1;
    checks++;
    if ({wr_ready_o, snp_data_we_o} !== 2'b10) begin
      errors++; $display("FAIL dr_accept: got rdy=%b dwe=%b want 1 0", wr_ready_o, snp_data_we_o);
    end
    @(negedge clk);
    wr_valid_i = 1'b0; wr_uncached_i = 1'b0;
    op_valid_i = 1'b1; op_type_i = 3'd1; op_addr_i = 32'h8000_2000; op_uncached_i = 1'b0;
    bus_gnt_i = 1'b1;
    #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_size_o, bus_strobe_o, bus_wdata_o} !== {1'b1, 1'b1, 32'hBFD0_0010, 2'd0, 4'h1, 32'h55}) begin
      errors++; $display("FAIL dr_wbus: got req=%b we=%b addr=%h size=%0d strb=%h data=%h want 1 1 bfd00010 0 1 00000055",
                         bus_req_o, bus_we_o, bus_addr_o, bus_size_o, bus_strobe_o, bus_wdata_o);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bus_gnt_i = 1'b0; #1;
      checks++;
      if ({bus_req_o, op_ready_o} !== 2'b00) begin
        errors++; $display("FAIL dr_hold[%0d]: got req=%b rdy=%b want 0 0", i, bus_req_o, op_ready_o);
      end
    end
    @(negedge clk); bus_bvalid_i = 1'b1; #1;
    checks++;
    if (bus_req_o !== 1'b0) begin
      errors++; $display("FAIL dr_bvalid: got req=%b want 0", bus_req_o);
    end
    @(negedge clk); bus_bvalid_i = 1'b0; #1;
    checks++;
    if ({bus_req_o, pending_write_o} !== 2'b00) begin
      errors++; $display("FAIL dr_empty: got req=%b pend=%b want 0 0", bus_req_o, pending_write_o);
    end
    @(negedge clk); bus_gnt_i = 1'b1; #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_len_o} !== {1'b1, 1'b0, 32'h8000_2000, 2'd3}) begin
      errors++; $display("FAIL dr_read: got req=%b we=%b addr=%h len=%0d want 1 0 80002000 3", bus_req_o, bus_we_o, bus_addr_o, bus_len_o);
    end
    @(negedge clk); bus_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); bus_rvalid_i = 1'b1; bus_rdata_i = 32'(k); bus_rlast_i = (k == 3);
    end
    @(negedge clk); bus_rvalid_i = 1'b0; bus_rlast_i = 1'b0;
    @(negedge clk); op_valid_i = 1'b0; #1;
    checks++;
    if (op_ready_o !== 1'b1) begin
      errors++; $display("FAIL dr_ready: got rdy=%b want 1", op_ready_o);
    end
  endtask

  task automatic test_uncached_read();
    @(negedge clk);
    op_valid_i = 1'b1; op_type_i = 3'd1; op_uncached_i = 1'b1; op_size_i = 2'd1; op_addr_i = 32'hBFD0_0002;
    #1;
    checks++;
    if (op_ready_o !== 1'b0) begin
      errors++; $display("FAIL ur_idle: got rdy=%b want 0", op_ready_o);
    end
    @(negedge clk); bus_gnt_i = 1'b1; #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_len_o, bus_size_o, snp_tag_we_o, snp_data_we_o} !==
        {1'b1, 1'b0, 32'hBFD0_0002, 2'd0, 2'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ur_req: got req=%b we=%b addr=%h len=%0d size=%0d twe=%b dwe=%b want 1 0 bfd00002 0 1 0 0",
                         bus_req_o, bus_we_o, bus_addr_o, bus_len_o, bus_size_o, snp_tag_we_o, snp_data_we_o);
    end
    @(negedge clk);
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_1234; bus_rlast_i = 1'b1;
    #1;
    checks++;
    if ({snp_tag_we_o, snp_data_we_o} !== 2'b00) begin
      errors++; $display("FAIL ur_nosnoop: got twe=%b dwe=%b want 0 0", snp_tag_we_o, snp_data_we_o);
    end
    @(negedge clk);
    bus_rvalid_i = 1'b0; bus_rlast_i = 1'b0; op_valid_i = 1'b0; op_uncached_i = 1'b0;
    #1;
    checks++;
    if ({op_ready_o, uncached_rdata_o, snp_tag_we_o, snp_data_we_o} !== {1'b1, 32'h0000_1234, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ur_done: got rdy=%b data=%h twe=%b dwe=%b want 1 00001234 0 0",
                         op_ready_o, uncached_rdata_o, snp_tag_we_o, snp_data_we_o);
    end
    @(negedge clk); #1;
    checks++;
    if ({op_ready_o, uncached_rdata_o} !== {1'b0, 32'h0000_1234}) begin
      errors++; $display("FAIL ur_hold: got rdy=%b data=%h want 0 00001234", op_ready_o, uncached_rdata_o);
    end
  endtask

  task automatic test_invalidate();
    @(negedge clk);
    op_valid_i = 1'b1; op_type_i = 3'd3; op_addr_i = 32'h0000_0050;
    #1;
    checks++;
    if ({op_ready_o, snp_tag_we_o} !== 2'b00) begin
      errors++; $display("FAIL inv_idle: got rdy=%b twe=%b want 0 0", op_ready_o, snp_tag_we_o);
    end
    @(negedge clk); #1;
    checks++;
    if ({snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, op_ready_o} !== {1'b1, 8'h05, 21'h0, 1'b0}) begin
      errors++; $display("FAIL inv_tag: got we=%b idx=%h tag=%h rdy=%b want 1 05 000000 0",
                         snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, op_ready_o);
    end
    @(negedge clk); op_valid_i = 1'b0; #1;
    checks++;
    if (op_ready_o !== 1'b1) begin
      errors++; $display("FAIL inv_ready: got rdy=%b want 1", op_ready_o);
    end
    // Unknown op type completes without touching bus or RAMs.
    @(negedge clk); op_valid_i = 1'b1; op_type_i = 3'd2; #1;
    checks++;
    if ({op_ready_o, bus_req_o} !== 2'b00) begin
      errors++; $display("FAIL other_idle: got rdy=%b req=%b want 0 0", op_ready_o, bus_req_o);
    end
    @(negedge clk); op_valid_i = 1'b0; #1;
    checks++;
    if ({op_ready_o, bus_req_o, snp_tag_we_o} !== 3'b100) begin
      errors++; $display("FAIL other_done: got rdy=%b req=%b twe=%b want 1 0 0", op_ready_o, bus_req_o, snp_tag_we_o);
    end
  endtask

  task automatic test_reset_mid_refill();
    int n;
    @(negedge clk);
    op_valid_i = 1'b1; op_type_i = 3'd1; op_uncached_i = 1'b0; op_addr_i = 32'h8000_3000;
    @(negedge clk); bus_gnt_i = 1'b1; #1;
    checks++;
    if (bus_req_o !== 1'b1) begin
      errors++; $display("FAIL rm_req: got req=%b want 1", bus_req_o);
    end
    @(negedge clk); bus_gnt_i = 1'b0;
    @(negedge clk); bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11; bus_rlast_i = 1'b0;
    @(negedge clk); bus_rdata_i = 32'h22;
    @(negedge clk); bus_rvalid_i = 1'b0; rst = 1'b1; #1;
    checks++;
    if ({bus_req_o, op_ready_o, wr_ready_o, pending_write_o, snp_tag_we_o} !== 5'b0) begin
      errors++; $display("FAIL rm_rst: got req=%b rdy=%b wrdy=%b pend=%b twe=%b want 0 0 0 0 0",
                         bus_req_o, op_ready_o, wr_ready_o, pending_write_o, snp_tag_we_o);
    end
    @(negedge clk);
    rst = 1'b0; op_valid_i = 1'b0; rd_valid_i = 1'b1; rd_vaddr_i = 32'h0000_0234;
    #1;
    checks++;
    if ({snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, wr_ready_o} !== {1'b1, 8'h00, 21'h0, 1'b0}) begin
      errors++; $display("FAIL rm_init: got we=%b idx=%h tag=%h wrdy=%b want 1 00 000000 0",
                         snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o, wr_ready_o);
    end
    @(negedge clk); rd_valid_i = 1'b0; #1;
    checks++;
    if (rd_valid_d1_o !== 1'b0) begin
      errors++; $display("FAIL rm_lookup_blocked: got v=%b want 0", rd_valid_d1_o);
    end
    n = 0;
    while (!wr_ready_o && n < 300) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if ({wr_ready_o, n} !== {1'b1, 32'd255}) begin
      errors++; $display("FAIL rm_init_len: got rdy=%b cycles=%0d want rdy=1 cycles=255", wr_ready_o, n);
    end
    @(negedge clk); rd_valid_i = 1'b1; rd_vaddr_i = 32'h0000_0234;
    @(negedge clk); rd_valid_i = 1'b0; #1;
    checks++;
    if ({rd_valid_d1_o, rd_tag_d1_o} !== {1'b1, 21'h0}) begin
      errors++; $display("FAIL rm_tag_cleared: got v=%b tag=%h want 1 000000", rd_valid_d1_o, rd_tag_d1_o);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1;
    rd_valid_i = 1'b0; rd_vaddr_i = '0;
    wr_valid_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; wr_strobe_i = '0; wr_uncached_i = 1'b0;
    op_valid_i = 1'b0; op_type_i = '0; op_addr_i = '0; op_uncached_i = 1'b0; op_size_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_rlast_i = 1'b0; bus_bvalid_i = 1'b0;
    test_reset();
    test_cached_write();
    test_refill();
    test_drain();
    test_uncached_read();
    test_invalidate();
    test_reset_mid_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
